// File: rtl/debouncer.sv
// rtl/debouncer.sv - single-bit debouncer/glitch filter; optional 2-flop input synchroniser via DEBOUNCER_SYNC_EN
module debouncer #(
  parameter int unsigned LENGTH = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned    CNT_W    = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

  logic             s_in;
  logic             out_q;
  logic             out_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef DEBOUNCER_SYNC_EN
  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;

  // Two-stage synchroniser bringing the raw pin into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign s_in = sync2_q;
`else
  // Input is already synchronous to clk; use it as-is
  assign s_in = in;
`endif

  // Count consecutive cycles of disagreement; flip out on the LENGTH-th one
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (s_in == out_q) begin
      // Any return to the current level restarts the qualification window
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s_in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state: counter and registered output level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - self-checking bench for debouncer with a history-window reference model
module tb_debouncer;

  localparam int LENGTH = 25;
`ifdef DEBOUNCER_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int LAT = LENGTH + SYNC_DLY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout;

  int n_cmp = 0;
  int n_bad = 0;

  debouncer #(.LENGTH(LENGTH)) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout)
  );

  always #5 clk = ~clk;

  // Posedge counter used as the time base for latency measurements
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor on the output, sampled away from the active edge
  logic prev_out = 1'b0;
  int   rise_n = 0;
  int   fall_n = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  always @(negedge clk) begin
    if (dout === 1'b1 && prev_out === 1'b0) begin
      rise_n   <= rise_n + 1;
      rise_cyc <= cyc;
    end
    if (dout === 1'b0 && prev_out === 1'b1) begin
      fall_n   <= fall_n + 1;
      fall_cyc <= cyc;
    end
    prev_out <= dout;
  end

  // Reference model: out takes a new level once the last LENGTH synchronised
  // samples all carry that level; synchronised sample = raw input SYNC_DLY edges earlier
  bit   in_hist[$];
  bit   s_hist[$];
  logic m_out = 1'b0;
  always @(posedge clk or negedge rst) begin : model
    bit s;
    bit all_same;
    if (!rst) begin
      in_hist.delete();
      s_hist.delete();
      m_out <= 1'b0;
    end else begin
      if (SYNC_DLY == 0) s = din;
      else if (in_hist.size() >= SYNC_DLY) s = in_hist[in_hist.size() - SYNC_DLY];
      else s = 1'b0;
      s_hist.push_back(s);
      all_same = (s_hist.size() >= LENGTH);
      if (all_same) begin
        for (int i = 0; i < LENGTH; i++) begin
          if (s_hist[s_hist.size() - 1 - i] != s) all_same = 1'b0;
        end
      end
      if (all_same && (s != m_out)) m_out <= s;
      in_hist.push_back(din);
      while (in_hist.size() > LENGTH + 4) void'(in_hist.pop_front());
      while (s_hist.size() > LENGTH + 4) void'(s_hist.pop_front());
    end
  end

  // Deviation tracking between DUT and model while stimulus is applied
  int   dev_cnt = 0;
  int   dev_cyc = 0;
  logic dev_act = 1'b0;
  logic dev_exp = 1'b0;

  task automatic step(input logic v, input int n);
    din = v;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dout !== m_out) begin
        if (dev_cnt == 0) begin
          dev_cyc = cyc;
          dev_act = dout;
          dev_exp = m_out;
        end
        dev_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    din = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_immediate: out=%b required=0", dout);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: out=%b required=0", i, dout);
      end
    end
    rst = 1'b1;
    dev_cnt = 0;
    step(1'b0, 5);
    n_cmp++;
    if (dout !== 1'b0 || dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset_release: out=%b required=0 model_dev=%0d", dout, dev_cnt);
    end
  endtask

  task automatic test_short_glitch();
    int r0;
    r0 = rise_n;
    dev_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2);
      step(1'b0, 2);
    end
    step(1'b0, 30);
    n_cmp++;
    if (rise_n !== r0 || dout !== 1'b0) begin
      n_bad++;
      $display("FAIL short_glitch: rises=%0d out=%b required rises=0 out=0", rise_n - r0, dout);
    end
    n_cmp++;
    if (dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL short_glitch_model: %0d cycles differ, first at cyc %0d out=%b required=%b", dev_cnt, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_near_threshold();
    int r0;
    r0 = rise_n;
    dev_cnt = 0;
    step(1'b1, 20);
    step(1'b0, 30);
    step(1'b1, 10);
    step(1'b0, 30);
    step(1'b1, LENGTH - 1);
    step(1'b0, 40);
    n_cmp++;
    if (rise_n !== r0 || dout !== 1'b0) begin
      n_bad++;
      $display("FAIL near_threshold: rises=%0d out=%b required rises=0 out=0", rise_n - r0, dout);
    end
    n_cmp++;
    if (dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL near_threshold_model: %0d cycles differ, first at cyc %0d out=%b required=%b", dev_cnt, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_pulse(input string name, input int width);
    int r0, f0, c0, c1, rl, fl;
    r0 = rise_n;
    f0 = fall_n;
    dev_cnt = 0;
    c0 = cyc;
    step(1'b1, width);
    c1 = cyc;
    step(1'b0, LAT + 15);
    rl = (rise_n != r0) ? rise_cyc - c0 : -1;
    fl = (fall_n != f0) ? fall_cyc - c1 : -1;
    n_cmp++;
    if (rl !== LAT) begin
      n_bad++;
      $display("FAIL %s_rise_latency: got %0d cycles required %0d", name, rl, LAT);
    end
    n_cmp++;
    if (fl !== LAT) begin
      n_bad++;
      $display("FAIL %s_fall_latency: got %0d cycles required %0d", name, fl, LAT);
    end
    n_cmp++;
    if (rl < 0 || fl < 0 || (fall_cyc - rise_cyc) !== width) begin
      n_bad++;
      $display("FAIL %s_high_width: got %0d cycles required %0d", name, fall_cyc - rise_cyc, width);
    end
    n_cmp++;
    if (dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL %s_model: %0d cycles differ, first at cyc %0d out=%b required=%b", name, dev_cnt, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_bounce_release();
    int f0, c0, fl;
    dev_cnt = 0;
    step(1'b1, 40);
    n_cmp++;
    if (dout !== 1'b1) begin
      n_bad++;
      $display("FAIL bounce_setup: out=%b required=1", dout);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2);
      n_cmp++;
      if (dout !== 1'b1) begin
        n_bad++;
        $display("FAIL bounce_hold_lo[%0d]: out=%b required=1", i, dout);
      end
      step(1'b1, 2);
      n_cmp++;
      if (dout !== 1'b1) begin
        n_bad++;
        $display("FAIL bounce_hold_hi[%0d]: out=%b required=1", i, dout);
      end
    end
    f0 = fall_n;
    c0 = cyc;
    step(1'b0, LAT + 15);
    fl = (fall_n != f0) ? fall_cyc - c0 : -1;
    n_cmp++;
    if (fl !== LAT) begin
      n_bad++;
      $display("FAIL bounce_fall_latency: got %0d cycles required %0d", fl, LAT);
    end
    n_cmp++;
    if (dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL bounce_model: %0d cycles differ, first at cyc %0d out=%b required=%b", dev_cnt, dev_cyc, dev_act, dev_exp);
    end
  endtask

  task automatic test_reset_mid_count();
    step(1'b1, 40);
    n_cmp++;
    if (dout !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_setup: out=%b required=1", dout);
    end
    step(1'b0, 10);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async: out=%b required=0 before next clk edge", dout);
    end
    @(negedge clk);
    rst = 1'b1;
    dev_cnt = 0;
    step(1'b0, 10);
    n_cmp++;
    if (dout !== 1'b0 || dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL midreset_after: out=%b required=0 model_dev=%0d", dout, dev_cnt);
    end
  endtask

  task automatic test_random();
    dev_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * LENGTH)));
    end
    step(1'b0, LAT + 5);
    n_cmp++;
    if (dev_cnt !== 0) begin
      n_bad++;
      $display("FAIL random_model: %0d cycles differ, first at cyc %0d out=%b required=%b", dev_cnt, dev_cyc, dev_act, dev_exp);
    end
    n_cmp++;
    if (dout !== 1'b0) begin
      n_bad++;
      $display("FAIL random_settle: out=%b required=0", dout);
    end
  endtask

  initial begin
    test_reset();
    test_short_glitch();
    test_near_threshold();
    test_pulse("valid_pulse", 50);
    test_pulse("boundary", LENGTH);
    test_bounce_release();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
